reg_write_scheduler: RTL and testbench

//  Schedules the single write port of the 11-entry register file (R0-R7, IH, SP, RA) and its T flag.

---
 rtl/reg_write_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_reg_write_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | reg_write_scheduler: arbitrates WB/INT/DBG onto the register-file write port and      |
// | keeps a RAW pending scoreboard. Optional bypass: define REG_WRITE_BYPASS_EN. Rev 1.0  |
// +--------------------------------------------------------------------------------------+
module reg_write_scheduler #(
  parameter int NUM_REGS     = 11,
  parameter int IDX_W        = 4,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_req,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_gnt,
  input  logic              int_req,
  input  logic [IDX_W-1:0]  int_idx,
  input  logic [DATA_W-1:0] int_data,
  output logic              int_gnt,
  input  logic              dbg_req,
  input  logic [IDX_W-1:0]  dbg_idx,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_gnt,
  input  logic              wb_t_req,
  input  logic              wb_t_val,
  input  logic              claim_valid,
  input  logic [IDX_W-1:0]  claim_idx,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rs_idx,
  input  logic [IDX_W-1:0]  rt_idx,
  input  logic [IDX_W-1:0]  rm_idx,
  output logic              hazard,
  output logic              rf_we_n,
  output logic [IDX_W-1:0]  rf_widx,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_t_we_n,
  output logic              rf_t_val,
  output logic              err_idx,
  output logic              fwd_s_hit,
  output logic              fwd_t_hit,
  output logic              fwd_m_hit,
  output logic [DATA_W-1:0] fwd_s_data,
  output logic [DATA_W-1:0] fwd_t_data,
  output logic [DATA_W-1:0] fwd_m_data
);
  localparam int                 CNT_W          = 8;
  localparam logic [CNT_W-1:0]   C_STARVE_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [IDX_W:0]     C_NUM_REGS     = (IDX_W+1)'(NUM_REGS);

  typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_DBG_PRIO = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                rf_we_n_q, rf_we_n_d;
  logic [IDX_W-1:0]    rf_widx_q, rf_widx_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                rf_t_we_n_q, rf_t_we_n_d;
  logic                rf_t_val_q, rf_t_val_d;
  logic                err_idx_q, err_idx_d;

  logic                any_gnt;
  logic [IDX_W-1:0]    sel_idx;
  logic [DATA_W-1:0]   sel_data;

  function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < C_NUM_REGS;
  endfunction

  // Out-of-range indices never match a scoreboard entry, so they read as not pending.
  function automatic logic is_pending(input logic [NUM_REGS-1:0] pend, input logic [IDX_W-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) hit = pend[i];
    end
    return hit;
  endfunction

  always_comb begin
    int_gnt = 1'b0;
    wb_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (int_req)                                 int_gnt = 1'b1;
      else if (state_q == ST_DBG_PRIO && dbg_req)  dbg_gnt = 1'b1;
      else if (wb_req)                             wb_gnt  = 1'b1;
      else if (dbg_req)                            dbg_gnt = 1'b1;
    end
  end

  always_comb begin
    any_gnt  = int_gnt | wb_gnt | dbg_gnt;
    sel_idx  = dbg_idx;
    sel_data = dbg_data;
    if (int_gnt) begin
      sel_idx  = int_idx;
      sel_data = int_data;
    end else if (wb_gnt) begin
      sel_idx  = wb_idx;
      sel_data = wb_data;
    end
  end

  always_comb begin
    rf_we_n_d  = 1'b1;
    rf_widx_d  = rf_widx_q;
    rf_wdata_d = rf_wdata_q;
    err_idx_d  = err_idx_q;
    // A bad index is still granted so the requester drains; only the write is suppressed.
    if (any_gnt) begin
      if (idx_valid(sel_idx)) begin
        rf_we_n_d  = 1'b0;
        rf_widx_d  = sel_idx;
        rf_wdata_d = sel_data;
      end else begin
        err_idx_d  = 1'b1;
      end
    end

    rf_t_we_n_d = ~wb_t_req;
    rf_t_val_d  = wb_t_req ? wb_t_val : rf_t_val_q;

    starve_cnt_d = starve_cnt_q;
    if (!dbg_req || dbg_gnt)               starve_cnt_d = '0;
    else if (starve_cnt_q != C_STARVE_LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;

    state_d = state_q;
    case (state_q)
      ST_NORMAL:   if (starve_cnt_q == C_STARVE_LIMIT) state_d = ST_DBG_PRIO;
      ST_DBG_PRIO: if (dbg_gnt)                        state_d = ST_NORMAL;
      default:                                         state_d = ST_NORMAL;
    endcase

    // Clear before set so a same-cycle claim keeps the entry pending.
    pending_d = pending_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_gnt && wb_idx == IDX_W'(i))         pending_d[i] = 1'b0;
      if (claim_valid && claim_idx == IDX_W'(i)) pending_d[i] = 1'b1;
    end
    if (flush) pending_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_NORMAL;
      starve_cnt_q <= '0;
      pending_q    <= '0;
      rf_we_n_q    <= 1'b1;
      rf_widx_q    <= '0;
      rf_wdata_q   <= '0;
      rf_t_we_n_q  <= 1'b1;
      rf_t_val_q   <= 1'b0;
      err_idx_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      pending_q    <= pending_d;
      rf_we_n_q    <= rf_we_n_d;
      rf_widx_q    <= rf_widx_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_t_we_n_q  <= rf_t_we_n_d;
      rf_t_val_q   <= rf_t_val_d;
      err_idx_q    <= err_idx_d;
    end
  end

  assign rf_we_n   = rf_we_n_q;
  assign rf_widx   = rf_widx_q;
  assign rf_wdata  = rf_wdata_q;
  assign rf_t_we_n = rf_t_we_n_q;
  assign rf_t_val  = rf_t_val_q;
  assign err_idx   = err_idx_q;

`ifdef REG_WRITE_BYPASS_EN
  assign fwd_s_hit  = ~rf_we_n_q && (rf_widx_q == rs_idx);
  assign fwd_t_hit  = ~rf_we_n_q && (rf_widx_q == rt_idx);
  assign fwd_m_hit  = ~rf_we_n_q && (rf_widx_q == rm_idx);
  assign fwd_s_data = rf_wdata_q;
  assign fwd_t_data = rf_wdata_q;
  assign fwd_m_data = rf_wdata_q;
`else
  assign fwd_s_hit  = 1'b0;
  assign fwd_t_hit  = 1'b0;
  assign fwd_m_hit  = 1'b0;
  assign fwd_s_data = '0;
  assign fwd_t_data = '0;
  assign fwd_m_data = '0;
`endif

  assign hazard = (is_pending(pending_q, rs_idx) & ~fwd_s_hit) |
                  (is_pending(pending_q, rt_idx) & ~fwd_t_hit) |
                  (is_pending(pending_q, rm_idx) & ~fwd_m_hit);

endmodule
`default_nettype wire

// File: tb/tb_reg_write_scheduler.sv
`default_nettype none
// tb_reg_write_scheduler: directed scenarios plus randomized traffic checked against a
// transaction-level model of arbitration, starvation promotion and the pending scoreboard.
module tb_reg_write_scheduler;
  localparam int NUM_REGS = 11, IDX_W = 4, DATA_W = 16, STARVE_LIMIT = 8;
`ifdef REG_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wb_req, int_req, dbg_req, wb_gnt, int_gnt, dbg_gnt;
  logic [IDX_W-1:0] wb_idx, int_idx, dbg_idx, claim_idx, rs_idx, rt_idx, rm_idx, rf_widx;
  logic [DATA_W-1:0] wb_data, int_data, dbg_data, rf_wdata, fwd_s_data, fwd_t_data, fwd_m_data;
  logic wb_t_req, wb_t_val, claim_valid, flush, hazard, rf_we_n, rf_t_we_n, rf_t_val, err_idx;
  logic fwd_s_hit, fwd_t_hit, fwd_m_hit;

  int tests_run = 0;
  int tests_failed = 0;

  reg_write_scheduler #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_idx(wb_idx), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .int_req(int_req), .int_idx(int_idx), .int_data(int_data), .int_gnt(int_gnt),
    .dbg_req(dbg_req), .dbg_idx(dbg_idx), .dbg_data(dbg_data), .dbg_gnt(dbg_gnt),
    .wb_t_req(wb_t_req), .wb_t_val(wb_t_val),
    .claim_valid(claim_valid), .claim_idx(claim_idx), .flush(flush),
    .rs_idx(rs_idx), .rt_idx(rt_idx), .rm_idx(rm_idx), .hazard(hazard),
    .rf_we_n(rf_we_n), .rf_widx(rf_widx), .rf_wdata(rf_wdata),
    .rf_t_we_n(rf_t_we_n), .rf_t_val(rf_t_val), .err_idx(err_idx),
    .fwd_s_hit(fwd_s_hit), .fwd_t_hit(fwd_t_hit), .fwd_m_hit(fwd_m_hit),
    .fwd_s_data(fwd_s_data), .fwd_t_data(fwd_t_data), .fwd_m_data(fwd_m_data)
  );

  always #5 clk = ~clk;

  task automatic idle();
    wb_req = 0; int_req = 0; dbg_req = 0;
    wb_idx = '0; int_idx = '0; dbg_idx = '0;
    wb_data = '0; int_data = '0; dbg_data = '0;
    wb_t_req = 0; wb_t_val = 0; claim_valid = 0; claim_idx = '0; flush = 0;
    rs_idx = '0; rt_idx = '0; rm_idx = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; wb_req = 1; int_req = 1; dbg_req = 1; claim_valid = 1; claim_idx = 4'd2; wb_t_req = 1;
    rs_idx = 4'd2;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({wb_gnt, int_gnt, dbg_gnt} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_gnt: got %b expected 000", {wb_gnt, int_gnt, dbg_gnt});
    end
    tests_run++;
    if ({rf_we_n, rf_t_we_n, rf_t_val, err_idx, hazard} !== 5'b11000) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected 11000", {rf_we_n, rf_t_we_n, rf_t_val, err_idx, hazard});
    end
    tests_run++;
    if ({rf_widx, rf_wdata} !== '0) begin
      tests_failed++; $display("FAIL reset_widx_wdata: got %h/%h expected 0/0", rf_widx, rf_wdata);
    end
    tests_run++;
    if ({fwd_s_hit, fwd_t_hit, fwd_m_hit, fwd_s_data} !== '0) begin
      tests_failed++; $display("FAIL reset_fwd: got %b data %h expected 0", {fwd_s_hit, fwd_t_hit, fwd_m_hit}, fwd_s_data);
    end
    idle(); rst = 0;
    tick();
  endtask

  task automatic test_priority_latency();
    wb_req = 1; wb_idx = 4'd2; wb_data = 16'hAAAA;
    int_req = 1; int_idx = 4'd5; int_data = 16'hBBBB;
    dbg_req = 1; dbg_idx = 4'd6; dbg_data = 16'hCCCC;
    #1;
    tests_run++;
    if ({wb_gnt, int_gnt, dbg_gnt} !== 3'b010) begin
      tests_failed++; $display("FAIL prio_int_first: got %b expected 010", {wb_gnt, int_gnt, dbg_gnt});
    end
    tick(); int_req = 0; #1;
    tests_run++;
    if ({rf_we_n, rf_widx, rf_wdata} !== {1'b0, 4'd5, 16'hBBBB}) begin
      tests_failed++; $display("FAIL prio_int_write: got %b/%h/%h expected 0/5/bbbb", rf_we_n, rf_widx, rf_wdata);
    end
    tests_run++;
    if ({wb_gnt, int_gnt, dbg_gnt} !== 3'b100) begin
      tests_failed++; $display("FAIL prio_wb_second: got %b expected 100", {wb_gnt, int_gnt, dbg_gnt});
    end
    tick(); wb_req = 0; #1;
    tests_run++;
    if ({rf_we_n, rf_widx, rf_wdata, dbg_gnt} !== {1'b0, 4'd2, 16'hAAAA, 1'b1}) begin
      tests_failed++; $display("FAIL prio_dbg_third: got %b/%h/%h gnt %b expected 0/2/aaaa gnt 1", rf_we_n, rf_widx, rf_wdata, dbg_gnt);
    end
    tick(); dbg_req = 0; #1;
    tests_run++;
    if ({rf_we_n, rf_widx, rf_wdata} !== {1'b0, 4'd6, 16'hCCCC}) begin
      tests_failed++; $display("FAIL prio_dbg_write: got %b/%h/%h expected 0/6/cccc", rf_we_n, rf_widx, rf_wdata);
    end
    tick();
    tests_run++;
    if (rf_we_n !== 1'b1) begin
      tests_failed++; $display("FAIL prio_idle: got rf_we_n=%b expected 1", rf_we_n);
    end
  endtask

  task automatic test_starvation();
    wb_req = 1; wb_idx = 4'd1; wb_data = 16'h0;
    dbg_req = 1; dbg_idx = 4'd7; dbg_data = 16'hD00D;
    for (int k = 0; k < 9; k++) begin
      #1;
      tests_run++;
      if ({wb_gnt, dbg_gnt} !== 2'b10) begin
        tests_failed++; $display("FAIL starve_refused_%0d: got wb/dbg %b expected 10", k, {wb_gnt, dbg_gnt});
      end
      tick(); wb_data = 16'(k);
    end
    #1;
    tests_run++;
    if ({wb_gnt, dbg_gnt} !== 2'b01) begin
      tests_failed++; $display("FAIL starve_promoted: got wb/dbg %b expected 01", {wb_gnt, dbg_gnt});
    end
    tick(); dbg_data = 16'h1111; #1;
    tests_run++;
    if ({rf_we_n, rf_widx, rf_wdata} !== {1'b0, 4'd7, 16'hD00D}) begin
      tests_failed++; $display("FAIL starve_dbg_write: got %b/%h/%h expected 0/7/d00d", rf_we_n, rf_widx, rf_wdata);
    end
    tests_run++;
    if ({wb_gnt, dbg_gnt} !== 2'b10) begin
      tests_failed++; $display("FAIL starve_back_normal: got wb/dbg %b expected 10", {wb_gnt, dbg_gnt});
    end
    tick(); wb_req = 0; #1;
    tests_run++;
    if (dbg_gnt !== 1'b1) begin
      tests_failed++; $display("FAIL starve_dbg_free: got %b expected 1", dbg_gnt);
    end
    tick(); idle(); tick();
  endtask

  task automatic test_scoreboard();
    claim_valid = 1; claim_idx = 4'd3;
    tick(); claim_valid = 0; rs_idx = 4'd3; #1;
    tests_run++;
    if (hazard !== 1'b1) begin
      tests_failed++; $display("FAIL sb_claim_rs: got %b expected 1", hazard);
    end
    rs_idx = 4'd0; rm_idx = 4'd3; #1;
    tests_run++;
    if (hazard !== 1'b1) begin
      tests_failed++; $display("FAIL sb_claim_rm: got %b expected 1", hazard);
    end
    rm_idx = 4'd0;
    tick(); claim_valid = 1; claim_idx = 4'd3; wb_req = 1; wb_idx = 4'd3; wb_data = 16'h1234; #1;
    tests_run++;
    if (wb_gnt !== 1'b1) begin
      tests_failed++; $display("FAIL sb_same_gnt: got %b expected 1", wb_gnt);
    end
    tick(); claim_valid = 0; wb_req = 0;
    tick(); rs_idx = 4'd3; #1;
    tests_run++;
    if (hazard !== 1'b1) begin
      tests_failed++; $display("FAIL sb_set_wins: got %b expected 1", hazard);
    end
    wb_req = 1; wb_idx = 4'd3;
    tick(); wb_req = 0;
    tick();
    tests_run++;
    if (hazard !== 1'b0) begin
      tests_failed++; $display("FAIL sb_wb_clear: got %b expected 0", hazard);
    end
    claim_valid = 1; claim_idx = 4'd2;
    tick(); claim_valid = 0; int_req = 1; int_idx = 4'd2; dbg_req = 1; dbg_idx = 4'd2;
    tick(); int_req = 0;
    tick(); dbg_req = 0;
    tick(); rs_idx = 4'd2; #1;
    tests_run++;
    if (hazard !== 1'b1) begin
      tests_failed++; $display("FAIL sb_int_dbg_keep: got %b expected 1", hazard);
    end
    flush = 1; claim_valid = 1; claim_idx = 4'd5;
    tick(); flush = 0; claim_valid = 0; rt_idx = 4'd5; #1;
    tests_run++;
    if (hazard !== 1'b0) begin
      tests_failed++; $display("FAIL sb_flush: got %b expected 0", hazard);
    end
    claim_valid = 1; claim_idx = 4'd13;
    tick(); claim_valid = 0; rs_idx = 4'd13; rt_idx = 4'd0; #1;
    tests_run++;
    if (hazard !== 1'b0) begin
      tests_failed++; $display("FAIL sb_oob: got %b expected 0", hazard);
    end
    idle();
  endtask

  task automatic test_t_path();
    tick(); wb_t_req = 1; wb_t_val = 1; int_req = 1; int_idx = 4'd0;
    tick(); int_req = 0; wb_t_val = 0; #1;
    tests_run++;
    if ({rf_t_we_n, rf_t_val} !== 2'b01) begin
      tests_failed++; $display("FAIL t_write1: got %b expected 01", {rf_t_we_n, rf_t_val});
    end
    tick(); wb_t_req = 0; #1;
    tests_run++;
    if ({rf_t_we_n, rf_t_val} !== 2'b00) begin
      tests_failed++; $display("FAIL t_write0: got %b expected 00", {rf_t_we_n, rf_t_val});
    end
    tick();
    tests_run++;
    if (rf_t_we_n !== 1'b1) begin
      tests_failed++; $display("FAIL t_idle: got %b expected 1", rf_t_we_n);
    end
  endtask

  task automatic test_bypass();
    tick(); wb_req = 1; wb_idx = 4'd9; wb_data = 16'hBEEF; claim_valid = 1; claim_idx = 4'd9;
    tick(); wb_req = 0; claim_valid = 0; rs_idx = 4'd0; rt_idx = 4'd9; rm_idx = 4'd1; #1;
    tests_run++;
    if ({fwd_s_hit, fwd_t_hit, fwd_m_hit} !== {1'b0, BYP, 1'b0}) begin
      tests_failed++; $display("FAIL byp_hit: got %b expected %b", {fwd_s_hit, fwd_t_hit, fwd_m_hit}, {1'b0, BYP, 1'b0});
    end
    tests_run++;
    if (fwd_t_data !== (BYP ? 16'hBEEF : 16'h0)) begin
      tests_failed++; $display("FAIL byp_data: got %h expected %h", fwd_t_data, BYP ? 16'hBEEF : 16'h0);
    end
    tests_run++;
    if (hazard !== !BYP) begin
      tests_failed++; $display("FAIL byp_hazard_mask: got %b expected %b", hazard, !BYP);
    end
    tick();
    tests_run++;
    if (hazard !== 1'b1) begin
      tests_failed++; $display("FAIL byp_hazard_after: got %b expected 1", hazard);
    end
    flush = 1;
    tick(); idle();
  endtask

  task automatic test_bad_index();
    dbg_req = 1; dbg_idx = 4'd12; dbg_data = 16'h7777; #1;
    tests_run++;
    if (dbg_gnt !== 1'b1) begin
      tests_failed++; $display("FAIL bad_gnt: got %b expected 1", dbg_gnt);
    end
    tick(); dbg_req = 0; #1;
    tests_run++;
    if ({rf_we_n, err_idx} !== 2'b11) begin
      tests_failed++; $display("FAIL bad_suppress: got we_n/err %b expected 11", {rf_we_n, err_idx});
    end
    tick(); wb_req = 1; wb_idx = 4'd0; wb_data = 16'h4242;
    tick(); wb_req = 0; #1;
    tests_run++;
    if ({rf_we_n, err_idx} !== 2'b01) begin
      tests_failed++; $display("FAIL bad_sticky: got we_n/err %b expected 01", {rf_we_n, err_idx});
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    claim_valid = 1; claim_idx = 4'd4; wb_req = 1; wb_idx = 4'd6; wb_data = 16'h5555;
    tick(); claim_valid = 0; wb_req = 0; rs_idx = 4'd4; #1;
    tests_run++;
    if ({rf_we_n, hazard} !== 2'b01) begin
      tests_failed++; $display("FAIL rstmid_pre: got we_n/hazard %b expected 01", {rf_we_n, hazard});
    end
    rst = 1; #1;
    tests_run++;
    if ({rf_we_n, hazard, err_idx, rf_widx} !== {3'b100, 4'd0}) begin
      tests_failed++; $display("FAIL rstmid_post: got we_n/haz/err %b widx %h expected 100 / 0", {rf_we_n, hazard, err_idx}, rf_widx);
    end
    tick(); idle(); rst = 0;
    tick();
  endtask

  task automatic test_random();
    bit pend[NUM_REGS];
    bit prio, e_we_n, e_t_we_n, e_t_val, e_err, e_haz, byp_hit;
    int refused, win;
    bit act[3];
    logic [IDX_W-1:0] ridx[3];
    logic [DATA_W-1:0] rdata[3];
    logic [IDX_W-1:0] src[3];
    logic [IDX_W-1:0] e_widx;
    logic [DATA_W-1:0] e_wdata;
    bit [2:0] e_hits;
    for (int i = 0; i < NUM_REGS; i++) pend[i] = 0;
    for (int r = 0; r < 3; r++) begin act[r] = 0; ridx[r] = '0; rdata[r] = '0; end
    prio = 0; refused = 0; e_we_n = 1; e_t_we_n = 1; e_t_val = 0; e_err = 0;
    e_widx = '0; e_wdata = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int r = 0; r < 3; r++) begin
        if (!act[r] && $urandom_range(0, 1) == 1) begin
          act[r] = 1;
          ridx[r] = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
          rdata[r] = 16'($urandom);
        end
      end
      wb_req = act[0]; wb_idx = ridx[0]; wb_data = rdata[0];
      int_req = act[1]; int_idx = ridx[1]; int_data = rdata[1];
      dbg_req = act[2]; dbg_idx = ridx[2]; dbg_data = rdata[2];
      claim_valid = ($urandom_range(0, 2) == 0); claim_idx = 4'($urandom_range(0, 12));
      flush = ($urandom_range(0, 29) == 0);
      rs_idx = 4'($urandom_range(0, 12)); rt_idx = 4'($urandom_range(0, 12)); rm_idx = 4'($urandom_range(0, 12));
      wb_t_req = 1'($urandom_range(0, 1)); wb_t_val = 1'($urandom_range(0, 1));
      #1;
      // Fixed priority list; the debug requester moves ahead of writeback once promoted.
      win = -1;
      if (act[1]) win = 1;
      else if (prio && act[2]) win = 2;
      else if (act[0]) win = 0;
      else if (act[2]) win = 2;
      src[0] = rs_idx; src[1] = rt_idx; src[2] = rm_idx;
      e_haz = 0;
      for (int s = 0; s < 3; s++) begin
        byp_hit = BYP && !e_we_n && (e_widx == src[s]);
        e_hits[2-s] = byp_hit;
        if (int'(src[s]) < NUM_REGS && !byp_hit) if (pend[int'(src[s])]) e_haz = 1;
      end
      tests_run++;
      if ({wb_gnt, int_gnt, dbg_gnt} !== {win == 0, win == 1, win == 2}) begin
        tests_failed++; $display("FAIL rnd_gnt cyc %0d: got %b expected %b", cyc, {wb_gnt, int_gnt, dbg_gnt}, {win == 0, win == 1, win == 2});
      end
      tests_run++;
      if (hazard !== e_haz) begin
        tests_failed++; $display("FAIL rnd_hazard cyc %0d: got %b expected %b", cyc, hazard, e_haz);
      end
      tests_run++;
      if ({rf_we_n, rf_t_we_n, err_idx} !== {e_we_n, e_t_we_n, e_err} ||
          (!e_we_n && {rf_widx, rf_wdata} !== {e_widx, e_wdata}) || (!e_t_we_n && rf_t_val !== e_t_val)) begin
        tests_failed++; $display("FAIL rnd_write cyc %0d: got %b/%h/%h t%b err%b expected %b/%h/%h t%b err%b",
          cyc, rf_we_n, rf_widx, rf_wdata, rf_t_val, err_idx, e_we_n, e_widx, e_wdata, e_t_val, e_err);
      end
      tests_run++;
      if ({fwd_s_hit, fwd_t_hit, fwd_m_hit} !== e_hits ||
          {fwd_s_data, fwd_t_data, fwd_m_data} !== (BYP ? {e_wdata, e_wdata, e_wdata} : 48'h0)) begin
        tests_failed++; $display("FAIL rnd_fwd cyc %0d: got %b %h expected %b %h", cyc, {fwd_s_hit, fwd_t_hit, fwd_m_hit}, fwd_s_data, e_hits, BYP ? e_wdata : 16'h0);
      end
      if (win >= 0) begin
        if (int'(ridx[win]) < NUM_REGS) begin e_we_n = 0; e_widx = ridx[win]; e_wdata = rdata[win]; end
        else begin e_we_n = 1; e_err = 1; end
      end else e_we_n = 1;
      e_t_we_n = !wb_t_req;
      if (wb_t_req) e_t_val = wb_t_val;
      if (flush) begin
        for (int i = 0; i < NUM_REGS; i++) pend[i] = 0;
      end else begin
        if (win == 0 && int'(ridx[0]) < NUM_REGS) pend[int'(ridx[0])] = 0;
        if (claim_valid && int'(claim_idx) < NUM_REGS) pend[int'(claim_idx)] = 1;
      end
      if (!prio && refused == STARVE_LIMIT) prio = 1;
      else if (prio && win == 2) prio = 0;
      if (act[2] && win != 2) refused = (refused < STARVE_LIMIT) ? refused + 1 : refused;
      else refused = 0;
      if (win >= 0) act[win] = 0;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_priority_latency();
    test_starvation();
    test_scoreboard();
    test_t_path();
    test_bypass();
    test_bad_index();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
